// File: rtl/tmip_stim_engine.sv
// TMIP stimulus/response engine: replays stored image, 3x3 template and action list into a
// TMIP-class DUT, then checks the out_valid burst for timeout and length. Optional macro: TMIP_CHKSUM_EN.
module tmip_stim_engine #(
    parameter int DATA_W    = 16,
    parameter int MAX_SIDE  = 16,
    parameter int ACT_DEPTH = 16,
    parameter int TIMEOUT   = 10000,
    parameter int OUT_W     = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [7:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic [4:0]        cfg_size,
    input  logic [4:0]        cfg_act_num,
    input  logic [2:0]        cfg_gap,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [8:0]        out_count,
    output logic [47:0]       chksum,
    output logic              in_valid,
    output logic              in_valid_2,
    output logic [DATA_W-1:0] image,
    output logic [DATA_W-1:0] template,
    output logic [4:0]        img_size,
    output logic [2:0]        action,
    input  logic              out_valid,
    input  logic [OUT_W-1:0]  out_value
);

    localparam int NPIX   = MAX_SIDE * MAX_SIDE;
    localparam int IDX_W  = $clog2(NPIX);
    localparam int AIDX_W = $clog2(ACT_DEPTH);
    localparam int CNT_W  = $clog2(TIMEOUT + NPIX + 8);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_IMG, S_SEP, S_ACT, S_WAIT, S_OUT, S_DONE
    } state_t;

    logic [DATA_W-1:0] img_mem  [NPIX];
    logic [DATA_W-1:0] tmpl_mem [9];
    logic [2:0]        act_mem  [ACT_DEPTH];

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_pix;
    logic [CNT_W-1:0] gap_len;
    logic [CNT_W-1:0] act_len;
    logic [4:0]       size_r;
    logic             size_ok;

    assign size_ok = (cfg_size == 5'd4) || (cfg_size == 5'd8) || (cfg_size == 5'(MAX_SIDE));

    // A zero action count still replays one entry; counts beyond the list depth are clamped.
    function automatic logic [CNT_W-1:0] eff_act(input logic [4:0] num);
        if (num == 5'd0) begin
            return CNT_W'(1);
        end else if (int'(num) > ACT_DEPTH) begin
            return CNT_W'(ACT_DEPTH);
        end else begin
            return CNT_W'(num);
        end
    endfunction

    // Config memories: written only between runs and never cleared by reset.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            case (cfg_sel)
                2'd0: if (int'(cfg_addr) < NPIX) img_mem[IDX_W'(cfg_addr)] <= cfg_wdata;
                2'd1: if (cfg_addr < 8'd9) tmpl_mem[cfg_addr[3:0]] <= cfg_wdata;
                2'd2: if (int'(cfg_addr) < ACT_DEPTH) act_mem[AIDX_W'(cfg_addr)] <= cfg_wdata[2:0];
                default: ;
            endcase
        end
    end

    // Run sequencer with registered DUT-side and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            n_pix      <= '0;
            gap_len    <= '0;
            act_len    <= '0;
            size_r     <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            out_count  <= 9'd0;
            in_valid   <= 1'b0;
            in_valid_2 <= 1'b0;
            image      <= '0;
            template   <= '0;
            img_size   <= 5'd0;
            action     <= 3'd0;
        end else begin
            done       <= 1'b0;
            in_valid   <= 1'b0;
            in_valid_2 <= 1'b0;
            image      <= '0;
            template   <= '0;
            img_size   <= 5'd0;
            action     <= 3'd0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        size_r    <= cfg_size;
                        n_pix     <= CNT_W'(cfg_size) * CNT_W'(cfg_size);
                        gap_len   <= (cfg_gap == 3'd0) ? CNT_W'(1) : CNT_W'(cfg_gap);
                        act_len   <= eff_act(cfg_act_num);
                        cnt       <= '0;
                        out_count <= 9'd0;
                        err_code  <= 2'd0;
                        if (size_ok) begin
                            state <= S_GAP;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == gap_len - CNT_W'(1)) begin
                        state    <= S_IMG;
                        in_valid <= 1'b1;
                        image    <= img_mem[0];
                        template <= tmpl_mem[0];
                        img_size <= size_r;
                        cnt      <= CNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_IMG: begin
                    if (cnt == n_pix) begin
                        state <= S_SEP;
                        cnt   <= '0;
                    end else begin
                        in_valid <= 1'b1;
                        image    <= img_mem[IDX_W'(cnt)];
                        template <= (cnt < CNT_W'(9)) ? tmpl_mem[cnt[3:0]] : '0;
                        cnt      <= cnt + CNT_W'(1);
                    end
                end
                S_SEP: begin
                    state      <= S_ACT;
                    in_valid_2 <= 1'b1;
                    action     <= act_mem[0];
                    cnt        <= CNT_W'(1);
                end
                S_ACT: begin
                    if (cnt == act_len) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else begin
                        in_valid_2 <= 1'b1;
                        action     <= act_mem[AIDX_W'(cnt)];
                        cnt        <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // The cycle that ends the wait is the first counted burst cycle.
                    if (out_valid) begin
                        state     <= S_OUT;
                        out_count <= 9'd1;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        err_code <= 2'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_valid) begin
                        out_count <= out_count + 9'd1;
                        if (CNT_W'(out_count) == n_pix) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end
                    end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (CNT_W'(out_count) < n_pix) begin
                            err      <= 1'b1;
                            err_code <= 2'd3;
                        end else begin
                            err      <= 1'b0;
                            err_code <= 2'd0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TMIP_CHKSUM_EN
    logic [47:0] chk_r;

    // Signed running sum of every counted burst sample, wrapping at 48 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_r <= 48'd0;
        end else if (state == S_IDLE && start) begin
            chk_r <= 48'd0;
        end else if ((state == S_WAIT || state == S_OUT) && out_valid) begin
            chk_r <= chk_r + {{(48 - OUT_W){out_value[OUT_W-1]}}, out_value};
        end
    end

    assign chksum = chk_r;
`else
    logic unused_out_value;
    assign unused_out_value = ^out_value;
    assign chksum = 48'd0;
`endif

endmodule

// File: tb/tb_tmip_stim_engine.sv
// Bench for tmip_stim_engine: per-run expected trace built from the protocol rules, checked every cycle.
module tb_tmip_stim_engine;
    localparam int TIMEOUT = 50;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cfg_we = 1'b0, start = 1'b0, out_valid = 1'b0;
    logic [1:0]  cfg_sel = 2'd3;
    logic [7:0]  cfg_addr = 8'd0;
    logic [15:0] cfg_wdata = 16'd0;
    logic [4:0]  cfg_size = 5'd0, cfg_act_num = 5'd0;
    logic [2:0]  cfg_gap = 3'd0;
    logic [39:0] out_value = 40'd0;
    logic        busy, done, err, in_valid, in_valid_2;
    logic [1:0]  err_code;
    logic [8:0]  out_count;
    logic [47:0] chksum;
    logic [15:0] image, template;
    logic [4:0]  img_size;
    logic [2:0]  action;

    tmip_stim_engine #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_size(cfg_size), .cfg_act_num(cfg_act_num), .cfg_gap(cfg_gap),
        .start(start), .busy(busy), .done(done), .err(err), .err_code(err_code),
        .out_count(out_count), .chksum(chksum), .in_valid(in_valid), .in_valid_2(in_valid_2),
        .image(image), .template(template), .img_size(img_size), .action(action),
        .out_valid(out_valid), .out_value(out_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy, done, iv, iv2, stat, err;
        logic [15:0] image, tmpl;
        logic [4:0]  sz;
        logic [2:0]  act;
        logic [1:0]  code;
        logic [8:0]  cnt;
        logic [47:0] chk;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_img [256];
    logic [15:0] m_tmpl [9];
    logic [2:0]  m_act [16];
    logic        h_err = 1'b0;
    logic [1:0]  h_code = 2'd0;
    logic [8:0]  h_cnt = 9'd0;
    logic [47:0] h_chk = 48'd0;
    bit          cmp_en = 1'b0;
    int          checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e = '{default: '0};
        e.stat = 1'b1; e.err = h_err; e.code = h_code; e.cnt = h_cnt; e.chk = h_chk;
        return e;
    endfunction

    // Single compare process: one expected entry per cycle, idle expectation when no run is scheduled.
    always @(posedge clk) begin : cmp
        exp_t e;
        #1;
        if (cmp_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_e();
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("in_valid", in_valid, e.iv);
            check("in_valid_2", in_valid_2, e.iv2);
            check("image", image, e.image);
            check("template", template, e.tmpl);
            check("img_size", img_size, e.sz);
            check("action", action, e.act);
            if (e.stat) begin
                check("err", err, e.err);
                check("err_code", err_code, e.code);
                check("out_count", out_count, e.cnt);
                check("chksum", chksum, e.chk);
                h_err = e.err; h_code = e.code; h_cnt = e.cnt; h_chk = e.chk;
            end
        end
    end

    task automatic wr(input logic [1:0] sel, input logic [7:0] addr, input logic [15:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        if (sel == 2'd0) m_img[addr] = data;
        else if (sel == 2'd1 && addr < 8'd9) m_tmpl[addr[3:0]] = data;
        else if (sel == 2'd2 && addr < 8'd16) m_act[addr[3:0]] = data[2:0];
    endtask

    task automatic wr_end();
        @(negedge clk);
        cfg_we = 1'b0; cfg_sel = 2'd3;
    endtask

    // Launch one run; the expected trace is derived from phase lengths: gap, N pixels, 1 separator, actions, wait, burst.
    task automatic run(input logic [4:0] sz, input logic [4:0] an, input logic [2:0] gp, input int lat,
                       input int rlen, input int rst_slot, input bit neg3, input bit bw,
                       output int d_o, output int w_o, output logic [47:0] sum_o);
        int n, g, a, w, d, cnt_e, last, k;
        bit ok;
        logic er;
        logic [1:0] code;
        logic [47:0] sum;
        logic [63:0] rnd;
        logic [39:0] vals[$];
        exp_t e;
        ok = (sz == 5'd4 || sz == 5'd8 || sz == 5'd16);
        g = (gp == 3'd0) ? 1 : int'(gp);
        a = (an == 5'd0) ? 1 : ((an > 5'd16) ? 16 : int'(an));
        n = int'(sz) * int'(sz);
        for (int i = 0; i < rlen; i++) begin
            rnd = {$urandom(), $urandom()};
            vals.push_back(neg3 ? 40'hFF_FFFF_FFFD : rnd[39:0]);
        end
        w = 0; cnt_e = 0; er = 1'b1; code = 2'd0;
        if (!ok) begin
            d = 1;
        end else begin
            w = g + n + a + 2;
            if (rlen == 0) begin
                d = w + TIMEOUT; code = 2'd1;
            end else if (rlen <= n) begin
                d = w + lat + rlen; cnt_e = rlen;
                er = (rlen < n); code = (rlen < n) ? 2'd3 : 2'd0;
            end else begin
                d = w + lat + n; cnt_e = n + 1; code = 2'd2;
            end
        end
        sum = 48'd0;
`ifdef TMIP_CHKSUM_EN
        for (int i = 0; i < cnt_e; i++) sum = sum + {{8{vals[i][39]}}, vals[i]};
`endif
        @(negedge clk);
        cfg_size = sz; cfg_act_num = an; cfg_gap = gp; start = 1'b1;
        for (int s = 1; s <= d; s++) begin
            e = '{default: '0};
            if (s == d) begin
                e.done = 1'b1; e.stat = 1'b1; e.err = er; e.code = code;
                e.cnt = 9'(cnt_e); e.chk = sum;
            end else begin
                e.busy = 1'b1;
                if (s >= g + 1 && s <= g + n) begin
                    k = s - g - 1;
                    e.iv = 1'b1; e.image = m_img[k];
                    e.tmpl = (k < 9) ? m_tmpl[k] : 16'd0;
                    e.sz = (k == 0) ? sz : 5'd0;
                end else if (s >= g + n + 2 && s <= g + n + 1 + a) begin
                    e.iv2 = 1'b1; e.act = m_act[s - g - n - 2];
                end
            end
            exp_q.push_back(e);
        end
        last = d;
        if (ok && rlen > 0 && w - 1 + lat + rlen > last) last = w - 1 + lat + rlen;
        for (int s = 1; s <= last; s++) begin
            @(negedge clk);
            start = 1'b0;
            cfg_size = 5'($urandom_range(0, 31)); cfg_gap = 3'($urandom_range(0, 7));
            cfg_act_num = 5'($urandom_range(0, 31));
            if (s == rst_slot) begin
                rst = 1'b1; exp_q.delete(); out_valid = 1'b0; cfg_we = 1'b0;
                h_err = 1'b0; h_code = 2'd0; h_cnt = 9'd0; h_chk = 48'd0;
                #1;
                check("async_rst_in_valid", in_valid, 1'b0);
                check("async_rst_busy", busy, 1'b0);
                @(negedge clk);
                rst = 1'b0; d_o = -1; w_o = w; sum_o = sum;
                return;
            end
            cfg_we = bw && ok && s == 2;
            cfg_sel = 2'd0; cfg_addr = 8'd0; cfg_wdata = ~m_img[0];
            out_valid = ok && rlen > 0 && s >= w - 1 + lat && s <= w - 2 + lat + rlen;
            rnd = {$urandom(), $urandom()};
            out_value = out_valid ? vals[s - (w - 1 + lat)] : rnd[39:0];
        end
        @(negedge clk);
        out_valid = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd3;
        d_o = d; w_o = w; sum_o = sum;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, w, n, rlen, m;
        logic [47:0] s;
        logic [4:0] sz;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) wr(2'd0, 8'(i), 16'($urandom()));
        for (int i = 0; i < 9; i++) wr(2'd1, 8'(i), 16'(i + 1));
        wr(2'd2, 8'd0, 16'd0);
        for (int i = 1; i < 16; i++) wr(2'd2, 8'(i), 16'($urandom()));
        for (int i = 9; i < 13; i++) wr(2'd1, 8'(i), 16'hDEAD);
        for (int i = 16; i < 21; i++) wr(2'd2, 8'(i), 16'h0007);
        wr(2'd3, 8'd1, 16'hBEEF);
        wr_end();

        run(5'd4, 5'd1, 3'd2, 1, 16, 0, 1'b1, 1'b1, d, w, s);
        check("pin_wait_slot", w, 21);
        check("pin_done_slot", d, 38);
`ifdef TMIP_CHKSUM_EN
        check("pin_chksum_minus48", s, 48'hFFFF_FFFF_FFD0);
`endif
        check("dir_out_count_16", out_count, 9'd16);
        check("dir_err_clear", err, 1'b0);

        run(5'd8, 5'd0, 3'd0, 1, 64, 0, 1'b0, 1'b0, d, w, s);
        check("pin_size8_done_slot", d, 133);

        run(5'd4, 5'd1, 3'd1, 1, 0, 0, 1'b0, 1'b0, d, w, s);
        check("pin_timeout_done_slot", d, 70);
        check("dir_timeout_code", err_code, 2'd1);

        run(5'd4, 5'd1, 3'd2, 3, 10, 0, 1'b0, 1'b0, d, w, s);
        check("pin_short_done_slot", d, 34);
        check("dir_short_code", err_code, 2'd3);
        check("dir_short_count", out_count, 9'd10);

        run(5'd4, 5'd1, 3'd2, 1, 17, 0, 1'b0, 1'b1, d, w, s);
        check("pin_long_done_slot", d, 38);
        check("dir_long_code", err_code, 2'd2);

        run(5'd5, 5'd1, 3'd2, 1, 16, 0, 1'b0, 1'b0, d, w, s);
        check("pin_badcfg_done_slot", d, 1);
        check("dir_badcfg_err", err, 1'b1);
        check("dir_badcfg_code", err_code, 2'd0);
        run(5'd0, 5'd3, 3'd4, 1, 16, 0, 1'b0, 1'b0, d, w, s);

        run(5'd8, 5'd2, 3'd3, 1, 64, 8, 1'b0, 1'b0, d, w, s);
        repeat (3) @(negedge clk);
        run(5'd4, 5'd1, 3'd2, 2, 16, 0, 1'b0, 1'b0, d, w, s);
        check("dir_after_rst_err", err, 1'b0);

        for (int r = 0; r < 12; r++) begin
            m = int'($urandom_range(0, 2));
            sz = (m == 0) ? 5'd4 : ((m == 1) ? 5'd8 : 5'd16);
            n = int'(sz) * int'(sz);
            m = int'($urandom_range(0, 9));
            if (m == 0) rlen = 0;
            else if (m <= 5) rlen = n;
            else if (m <= 7) rlen = int'($urandom_range(1, n - 1));
            else rlen = n + int'($urandom_range(1, 3));
            run(sz, 5'($urandom_range(0, 16)), 3'($urandom_range(0, 7)), int'($urandom_range(1, 10)),
                rlen, 0, 1'b0, r[0], d, w, s);
            wr(2'd0, 8'($urandom_range(0, 255)), 16'($urandom()));
            wr(2'd2, 8'($urandom_range(0, 15)), 16'($urandom()));
            wr_end();
        end
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
